// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: drives PC / IF/ID / ID/EX
// enables and flushes for load-use, mult/div occupancy, imem wait and redirect flushes.
//
// state   | meaning
// RUN     | normal issue; hazards resolved combinationally each cycle
// MD_WAIT | mult/div held in ID until its latency has elapsed
module hazard_ctrl #(
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_muldiv,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             ex_redirect,
   input  logic             imem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int MDW = ($clog2(MD_LAT + 1) > 3) ? $clog2(MD_LAT + 1) : 3;

   typedef enum logic {RUN, MD_WAIT} state_t;

   state_t           state_q, state_d;
   logic [MDW-1:0]   md_cnt_q, md_cnt_d;
   logic             md_rel_q, md_rel_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             lu;

   assign lu = ex_mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   always_comb begin
      state_d    = state_q;
      md_cnt_d   = md_cnt_q;
      md_rel_d   = md_rel_q;
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (!reset) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (ex_redirect) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         state_d    = RUN;
         md_cnt_d   = '0;
         md_rel_d   = 1'b0;
      end else if (state_q == MD_WAIT) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
         md_cnt_d   = md_cnt_q - MDW'(1);
         if (md_cnt_q == MDW'(1)) begin
            state_d  = RUN;
            md_rel_d = 1'b1;
         end
      end else if (lu) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else if (id_muldiv && !md_rel_q) begin
         // md_cnt counts MD_WAIT cycles; the entry cycle is the first stall cycle.
         // md_rel marks the held mult/div as released so RUN does not re-stall it.
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
         if (MD_LAT > 2) begin
            state_d  = MD_WAIT;
            md_cnt_d = MDW'(MD_LAT - 2);
         end else begin
            md_rel_d = 1'b1;
         end
      end else if (!imem_ready) begin
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
         md_rel_d   = 1'b0;
      end else begin
         md_rel_d   = 1'b0;
      end

      stall_d = stall_q;
      if (!ifid_en && (stall_q != '1))
         stall_d = stall_q + CNT_W'(1);
      flush_d = flush_q;
      if (ex_redirect && (flush_q != '1))
         flush_d = flush_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= RUN;
         md_cnt_q <= '0;
         md_rel_q <= 1'b0;
         stall_q  <= '0;
         flush_q  <= '0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
         md_rel_q <= md_rel_d;
         stall_q  <= stall_d;
         flush_q  <= flush_d;
      end
   end

   assign md_busy   = (state_q == MD_WAIT);
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule
